pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Owns the architectural PC register and drives instruction fetch. Publishes the current pc
//     to the next-PC logic and loads that logic's npc result when the core retires the
//     current instruction.
//   Runs a request/response handshake to instruction memory and holds one fetched
//     instruction until the core accepts it.
//   Sits between imem and the core datapath; it is the consumer end of the next-PC path.
// PARAMETERS
//   RESET_PC   32'h0000_0000   pc value loaded on reset
// PORTS
//   clk             input   1   system clock, all state on rising edge
//   rst             input   1   asynchronous, active-high reset
//   npc             input   32  next PC from next-PC logic; sampled only on retire
//   pc              output  32  PC of the instruction being fetched/held; feeds next-PC logic
//   imem_req_valid  output  1   fetch request valid
//   imem_req_addr   output  32  fetch address (always equals pc)
//   imem_req_ready  input   1   imem accepts the request this cycle
//   imem_resp_valid input   1   fetch data valid
//   imem_resp_data  input   32  fetched instruction word
//   inst_valid      output  1   inst holds a valid instruction for pc
//   inst            output  32  held instruction word
//   inst_ready      input   1   core retires inst this cycle (retire = inst_valid & inst_ready)
//   misalign_err    output  1   sticky: npc[1:0] != 0 was loaded on a retire
// BEHAVIOUR
//   Reset, asynchronous:
//     pc=RESET_PC, state=REQ, inst=0, misalign_err=0; all other outputs 0.
//   FSM states:
//     REQ   imem_req_valid=1.
//             req_ready & resp_valid in the same cycle -> capture data, go to VALID.
//             req_ready alone -> WAIT.
//             Otherwise stay in REQ.
//     WAIT  imem_req_valid=0. resp_valid -> capture resp_data into inst, go to VALID.
//     VALID inst_valid=1, inst stable. Retire -> pc<=npc.
//             npc[1:0]==0 -> go to REQ.
//             Otherwise set misalign_err=1 and go to ERR.
//     ERR   No requests, inst_valid=0, pc holds the faulting npc. Left only by reset.
//   Latency: retire->next request is 1 cycle. Minimum 2 cycles per instruction with a
//     same-cycle-response memory: REQ, then VALID.
//   pc changes only on retire. imem_req_addr is stable while imem_req_valid=1 and unaccepted.
//   resp_valid in REQ without req_ready, or in VALID or ERR, is ignored.
//   npc is not sampled outside a retire.
//   inst_ready while inst_valid=0 has no effect.
//   pc wraps 32'hFFFF_FFFC -> whatever npc supplies; no arithmetic is done here.
//   Reset asserted mid-WAIT: state returns to REQ at RESET_PC.
//     A late response after reset release is ignored unless the FSM is in WAIT.
// CONFIGURATION
//   RETIRE_CNT_EN defined:
//     Adds output retire_cnt [31:0]: number of retires since reset.
//     Reset value 0, +1 per retire, wraps from 32'hFFFF_FFFF to 0.
//     Adds output last_pc [31:0]: pc of the most recently retired instruction. Reset value 0.
//     A retire that enters ERR still counts.
//   RETIRE_CNT_EN undefined: neither port exists and no counter logic is built.
// TESTING
//   1. Reset release, imem req_ready=1 and resp 0x00500093 in the same cycle.
//        -> imem_req_addr=0x0, then inst_valid=1 with inst=0x00500093 next cycle.
//   2. Resp delayed 3 cycles after acceptance.
//        -> WAIT for 3 cycles with imem_req_valid=0, then VALID.
//           inst_valid stays 0 throughout WAIT.
//   3. VALID at pc=0x10, npc=0x14, inst_ready=1.
//        -> pc=0x14 next cycle and imem_req_addr=0x14.
//      Then npc=0x40 (taken branch).
//        -> the following fetch goes to 0x40.
//   4. inst_ready held 0 for 5 cycles in VALID while npc toggles.
//        -> pc and inst unchanged, no new request issued.
//   5. Retire with npc=0x0000_0022.
//        -> misalign_err=1, pc=0x22, imem_req_valid=0 permanently.
//      Assert rst.
//        -> pc=RESET_PC, err cleared.
//   6. RETIRE_CNT_EN: 3 retires at pc 0x0, 0x4, 0x8.
//        -> retire_cnt=3, last_pc=0x8.
//      Preload the count to 0xFFFF_FFFF (force), then 1 retire.
//        -> retire_cnt=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: one outstanding imem request, one held instruction.
// Optional retire counter / last-retired-pc outputs are built when RETIRE_CNT_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    input  logic        inst_ready,
    output logic        misalign_err
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt,
    output logic [31:0] last_pc
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_VALID,
        S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic        retire;

    assign retire = (state_q == S_VALID) && inst_ready;

    always_comb begin
        // NOTE: every next-state value gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        unique case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    if (imem_resp_valid) begin
                        inst_d  = imem_resp_data;
                        state_d = S_VALID;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    inst_d  = imem_resp_data;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (retire) begin
                    pc_d = npc;
                    // A misaligned target is loaded into pc so the faulting address stays visible.
                    if (npc[1:0] == 2'b00) begin
                        state_d = S_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    // Request is masked while reset is held so every output reads 0 during reset.
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;
    assign inst_valid     = (state_q == S_VALID);
    assign inst           = inst_q;
    assign misalign_err   = err_q;

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] last_pc_q, last_pc_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        last_pc_d    = last_pc_q;
        if (retire) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
            last_pc_d    = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= 32'h0;
            last_pc_q    <= 32'h0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            last_pc_q    <= last_pc_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign last_pc    = last_pc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Transaction-level bench for pc_fetch_unit: each instruction is a randomized fetch
// (accept delay, response delay, hold time, next pc) with expectations derived per phase.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        misalign_err;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    logic [31:0] last_pc;
`endif

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .npc             (npc),
        .pc              (pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_ready      (inst_ready),
        .misalign_err    (misalign_err)
`ifdef RETIRE_CNT_EN
        ,
        .retire_cnt      (retire_cnt),
        .last_pc         (last_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Architectural model: what the unit should publish, updated only at retire and reset.
    logic [31:0] exp_pc;
    logic        exp_err;
    logic [31:0] exp_cnt;
    logic [31:0] exp_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit exp_req, input bit exp_ival, input logic [31:0] exp_inst);
        check("pc", pc, exp_pc);
        check("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        check("imem_req_addr", imem_req_addr, exp_pc);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_ival});
        if (exp_ival) check("inst", inst, exp_inst);
        check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_err});
`ifdef RETIRE_CNT_EN
        check("retire_cnt", retire_cnt, exp_cnt);
        check("last_pc", last_pc, exp_last);
`endif
    endtask

    task automatic model_reset();
        exp_pc   = RESET_PC;
        exp_err  = 1'b0;
        exp_cnt  = 32'h0;
        exp_last = 32'h0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 32'h0);
        check("inst_after_reset", inst, 32'h0);
        repeat (2) @(negedge clk);
        rst             = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b0;
    endtask

    // One instruction: ready_delay cycles unaccepted, acceptance, wait_cycles in flight
    // (response on the last one; 0 = same-cycle response), hold cycles unretired, then retire.
    task automatic fetch_one(input logic [31:0] data, input int ready_delay, input int wait_cycles,
                             input int hold, input logic [31:0] next_pc);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            check_outputs(1'b1, 1'b0, 32'h0);
            imem_req_ready  = 1'b0;
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            inst_ready      = 1'($urandom_range(0, 1));
            npc             = $urandom;
        end
        @(negedge clk);
        check_outputs(1'b1, 1'b0, 32'h0);
        imem_req_ready  = 1'b1;
        imem_resp_valid = (wait_cycles == 0);
        imem_resp_data  = (wait_cycles == 0) ? data : $urandom;
        inst_ready      = 1'($urandom_range(0, 1));
        npc             = $urandom;
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            check_outputs(1'b0, 1'b0, 32'h0);
            imem_req_ready  = 1'($urandom_range(0, 1));
            imem_resp_valid = (i == wait_cycles - 1);
            imem_resp_data  = (i == wait_cycles - 1) ? data : $urandom;
            inst_ready      = 1'($urandom_range(0, 1));
            npc             = $urandom;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_outputs(1'b0, 1'b1, data);
            imem_req_ready  = 1'($urandom_range(0, 1));
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            inst_ready      = 1'b0;
            npc             = $urandom;
        end
        @(negedge clk);
        check_outputs(1'b0, 1'b1, data);
        imem_req_ready  = 1'($urandom_range(0, 1));
        imem_resp_valid = 1'($urandom_range(0, 1));
        imem_resp_data  = $urandom;
        inst_ready      = 1'b1;
        npc             = next_pc;
        exp_cnt  = exp_cnt + 32'd1;
        exp_last = exp_pc;
        exp_pc   = next_pc;
        if (next_pc[1:0] != 2'b00) exp_err = 1'b1;
    endtask

    task automatic error_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_outputs(1'b0, 1'b0, 32'h0);
            imem_req_ready  = 1'($urandom_range(0, 1));
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            inst_ready      = 1'($urandom_range(0, 1));
            npc             = $urandom;
        end
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        check_outputs(1'b1, 1'b0, 32'h0);
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b0;
        @(negedge clk);
        check_outputs(1'b0, 1'b0, 32'h0);
        imem_req_ready = 1'b0;
        rst            = 1'b1;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst             = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] next_v;
        int          r;
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b1;
        npc             = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;
        model_reset();
        reset_dut();

        fetch_one(32'h0050_0093, 0, 0, 0, 32'h0000_0004);
        fetch_one($urandom, 0, 3, 0, 32'h0000_0008);
        fetch_one($urandom, 1, 0, 1, 32'h0000_0010);
        fetch_one($urandom, 0, 1, 0, 32'h0000_0014);
        fetch_one($urandom, 0, 0, 0, 32'h0000_0040);
        fetch_one($urandom, 0, 0, 5, 32'h0000_0044);
        fetch_one($urandom, 2, 2, 0, 32'h0000_0022);
        error_phase(4);
        reset_dut();

`ifdef RETIRE_CNT_EN
        @(negedge clk);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        fetch_one($urandom, 0, 0, 0, 32'h0000_0004);
        fetch_one($urandom, 0, 0, 0, 32'h0000_0008);
`endif

        fetch_one($urandom, 0, 1, 0, 32'hFFFF_FFFC);
        fetch_one($urandom, 1, 0, 0, 32'h0000_0100);
        reset_mid_wait();

        for (int n = 0; n < 150; n++) begin
            r      = int'($urandom_range(0, 19));
            next_v = $urandom;
            if (r == 0) begin
                next_v[1:0] = 2'($urandom_range(1, 3));
            end else if (r < 12) begin
                next_v = exp_pc + 32'd4;
            end else begin
                next_v[1:0] = 2'b00;
            end
            fetch_one($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), next_v);
            if (r == 0) begin
                error_phase(int'($urandom_range(1, 4)));
                reset_dut();
            end else if ($urandom_range(0, 24) == 0) begin
                reset_mid_wait();
            end
        end

        @(negedge clk);
        check_outputs(1'b1, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
